hough_frame_sequencer: RTL and testbench
========================================

HOUGH_FRAME_SEQUENCER -- requirements
Module: hough_frame_sequencer

Interface
REQ-001 Parameter WIDTH, default 512: frame width in pixels.
REQ-002 Parameter HEIGHT, default 288: frame height in lines; TOTAL = WIDTH*HEIGHT, counters sized clog2(TOTAL+1).
REQ-003 The block SHALL use one clock, clk, and one reset, rst, which is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 vip_ctrl_valid  in  1  control packet decoded; width_in/height_in valid.
REQ-007 width_in, height_in  in  16 each  decoded frame size.
REQ-008 vip_ctrl_busy  in  1  control encoder busy.
REQ-009 vip_ctrl_send  out  1  one-cycle request to emit control packet.
REQ-010 width_out, height_out  out  16 each  size sent downstream.
REQ-011 src_valid  in  1  source pixel present (not stalled).
REQ-012 src_ready  out  1  pixel may be accepted (drives core read).
REQ-013 core_full  in  1  processing core input FIFO full.
REQ-014 core_wr_en  out  1  push pixel into core.
REQ-015 core_empty  in  1  core output FIFO empty.
REQ-016 core_rd_en  out  1  pop core output; data valid next cycle.
REQ-017 sink_stall  in  1  downstream stall.
REQ-018 sink_write  out  1  output word present to sink.
REQ-019 end_of_video_out  out  1  marks last word of frame, qualified by sink_write.
REQ-020 frame_busy  out  1  high in any state but IDLE.
REQ-021 size_error  out  1  sticky: last control packet size differed from WIDTH/HEIGHT.
REQ-022 frame_count  out  16  completed frames, wraps at 65535->0.

Function
REQ-023 States IDLE, CTRL, STREAM, DONE; one registered state vector.
REQ-024 IDLE: on vip_ctrl_valid -> CTRL; size_error <= (width_in!=WIDTH)|(height_in!=HEIGHT); width_out/height_out <= WIDTH/HEIGHT always (core geometry fixed).
REQ-025 vip_ctrl_valid outside IDLE SHALL be ignored (no latch, no size_error change).
REQ-026 CTRL: vip_ctrl_send registered high for exactly one cycle on the first cycle with vip_ctrl_busy=0, then -> STREAM; stays in CTRL while busy.
REQ-027 src_ready = (state==STREAM) & ~core_full & (in_cnt<TOTAL); core_wr_en = src_valid & src_ready, combinational.
REQ-028 in_cnt increments on each core_wr_en; no accept after TOTAL pixels.
REQ-029 core_rd_en = (state==STREAM) & ~core_empty & (rd_cnt<TOTAL) & (~sink_write | ~sink_stall), combinational; rd_cnt increments per pop.
REQ-030 sink_write registered: set cycle after core_rd_en; held while sink_stall=1; cleared when accepted (sink_write & ~sink_stall) with no new pop that cycle.
REQ-031 Word accepted iff sink_write & ~sink_stall; out_cnt increments per acceptance.
REQ-032 end_of_video_out = sink_write & (out_cnt==TOTAL-1), held through stall.
REQ-033 Input and output sides run concurrently in STREAM; no pop beyond TOTAL even if core non-empty.
REQ-034 Acceptance of word TOTAL-1 -> DONE; DONE lasts one cycle: frame_count+1, counters cleared, -> IDLE.
REQ-035 Latency: core_rd_en to sink_write = 1 cycle; last acceptance to frame_busy low = 2 cycles.

Reset
REQ-036 rst=0 at a clock edge: state IDLE, in_cnt/rd_cnt/out_cnt=0, vip_ctrl_send=0, sink_write=0, size_error=0, frame_count=0, width_out=WIDTH, height_out=HEIGHT; combinational outputs follow to 0.
REQ-037 Reset mid-frame SHALL abandon the frame without incrementing frame_count; core flush is the core's own reset's responsibility.

Verification (WIDTH=4, HEIGHT=2, TOTAL=8)
REQ-038 Reset, vip_ctrl_valid with 4x2, busy=0 -> vip_ctrl_send single pulse 1 cycle after CTRL entry; width_out=4, height_out=2, size_error=0.
REQ-039 Stream 8 pixels, core echoes, no stall -> exactly 8 core_wr_en, 8 sink_write words, end_of_video_out only on 8th, frame_count=1.
REQ-040 sink_stall high 3 cycles while sink_write=1 on word 5 -> word held, core_rd_en=0 throughout, single acceptance, total still 8.
REQ-041 src_valid continuous, core_full high 2 cycles -> src_ready=0, no core_wr_en those cycles; 9th pixel never accepted.
REQ-042 vip_ctrl_valid 640x480 -> size_error=1, outputs 4/2; vip_ctrl_valid during STREAM ignored.
REQ-043 rst low after 5 outputs -> next cycle IDLE, frame_busy=0, frame_count unchanged, counts 0.

Source files
------------

// File: rtl/hough_frame_sequencer_if.sv
// Handshake and status bundle between the Hough frame sequencer and its
// neighbours: control-packet codec, pixel source, processing core and sink.
interface hough_frame_sequencer_if;
    logic        vip_ctrl_valid;
    logic [15:0] width_in;
    logic [15:0] height_in;
    logic        vip_ctrl_busy;
    logic        vip_ctrl_send;
    logic [15:0] width_out;
    logic [15:0] height_out;
    logic        src_valid;
    logic        src_ready;
    logic        core_full;
    logic        core_wr_en;
    logic        core_empty;
    logic        core_rd_en;
    logic        sink_stall;
    logic        sink_write;
    logic        end_of_video_out;
    logic        frame_busy;
    logic        size_error;
    logic [15:0] frame_count;

    // Sequencer side: it issues the control, push, pop and sink strobes
    modport master (
        input  vip_ctrl_valid, width_in, height_in, vip_ctrl_busy,
               src_valid, core_full, core_empty, sink_stall,
        output vip_ctrl_send, width_out, height_out, src_ready, core_wr_en,
               core_rd_en, sink_write, end_of_video_out, frame_busy,
               size_error, frame_count
    );

    // Environment side: codec, source, core and sink
    modport slave (
        output vip_ctrl_valid, width_in, height_in, vip_ctrl_busy,
               src_valid, core_full, core_empty, sink_stall,
        input  vip_ctrl_send, width_out, height_out, src_ready, core_wr_en,
               core_rd_en, sink_write, end_of_video_out, frame_busy,
               size_error, frame_count
    );
endinterface

// File: rtl/hough_frame_sequencer.sv
// Frame sequencer for a fixed-geometry Hough core: forwards a control packet,
// meters exactly one frame of pixels into the core, drains exactly one frame of
// results to the sink, then counts the frame and returns to idle.
module hough_frame_sequencer #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 288
) (
    input  logic                    clk,
    input  logic                    rst,
    hough_frame_sequencer_if.master bus
);
    localparam int              TOTAL     = WIDTH * HEIGHT;
    localparam int              CW        = $clog2(TOTAL + 1);
    localparam logic [CW-1:0]   TOTAL_CNT = CW'(TOTAL);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(TOTAL - 1);
    localparam logic [15:0]     WIDTH_W   = 16'(WIDTH);
    localparam logic [15:0]     HEIGHT_W  = 16'(HEIGHT);

    typedef enum logic [1:0] {IDLE, CTRL, STREAM, DONE} state_t;

    state_t        state;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] out_cnt;
    logic          vip_ctrl_send;
    logic          sink_write;
    logic          size_error;
    logic [15:0]   width_out;
    logic [15:0]   height_out;
    logic [15:0]   frame_count;
    logic          src_ready;
    logic          core_wr_en;
    logic          core_rd_en;
    logic          accept;

    // Flow control: the input and output sides run independently while streaming,
    // each capped at one frame; a pop is allowed only when the output slot frees up
    always_comb begin
        src_ready  = (state == STREAM) && !bus.core_full && (in_cnt < TOTAL_CNT);
        core_wr_en = bus.src_valid && src_ready;
        core_rd_en = (state == STREAM) && !bus.core_empty && (rd_cnt < TOTAL_CNT) &&
                     (!sink_write || !bus.sink_stall);
        accept     = sink_write && !bus.sink_stall;
    end

    // Frame state machine with all registered outputs and counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            in_cnt        <= '0;
            rd_cnt        <= '0;
            out_cnt       <= '0;
            vip_ctrl_send <= 1'b0;
            sink_write    <= 1'b0;
            size_error    <= 1'b0;
            frame_count   <= 16'd0;
            width_out     <= WIDTH_W;
            height_out    <= HEIGHT_W;
        end else begin
            vip_ctrl_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.vip_ctrl_valid) begin
                        size_error <= (bus.width_in != WIDTH_W) || (bus.height_in != HEIGHT_W);
                        width_out  <= WIDTH_W;
                        height_out <= HEIGHT_W;
                        state      <= CTRL;
                    end
                end
                CTRL: begin
                    if (!bus.vip_ctrl_busy) begin
                        vip_ctrl_send <= 1'b1;
                        state         <= STREAM;
                    end
                end
                STREAM: begin
                    if (core_wr_en) begin
                        in_cnt <= in_cnt + 1'b1;
                    end
                    if (core_rd_en) begin
                        rd_cnt     <= rd_cnt + 1'b1;
                        sink_write <= 1'b1;
                    end else if (accept) begin
                        sink_write <= 1'b0;
                    end
                    if (accept) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt == LAST_CNT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    frame_count <= frame_count + 16'd1;
                    in_cnt      <= '0;
                    rd_cnt      <= '0;
                    out_cnt     <= '0;
                    sink_write  <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vip_ctrl_send    = vip_ctrl_send;
    assign bus.width_out        = width_out;
    assign bus.height_out       = height_out;
    assign bus.src_ready        = src_ready;
    assign bus.core_wr_en       = core_wr_en;
    assign bus.core_rd_en       = core_rd_en;
    assign bus.sink_write       = sink_write;
    assign bus.end_of_video_out = sink_write && (out_cnt == LAST_CNT);
    assign bus.frame_busy       = (state != IDLE);
    assign bus.size_error       = size_error;
    assign bus.frame_count      = frame_count;
endmodule

// File: tb/tb_hough_frame_sequencer.sv
// Self-checking bench for hough_frame_sequencer with a 4x2 frame. A count-based
// model (pixels pushed, words popped, words accepted, core occupancy) predicts
// every handshake output each cycle under directed and randomized stimulus.
module tb_hough_frame_sequencer;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int TOTAL = W * H;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] fc_exp   = 16'd0;
    bit          size_err_exp = 1'b0;

    hough_frame_sequencer_if bus();

    hough_frame_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run
    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.vip_ctrl_valid = 1'b0;
        bus.width_in       = 16'd0;
        bus.height_in      = 16'd0;
        bus.vip_ctrl_busy  = 1'b0;
        bus.src_valid      = 1'b0;
        bus.core_full      = 1'b0;
        bus.core_empty     = 1'b1;
        bus.sink_stall     = 1'b0;
    endtask

    task automatic recover();
        quiet_inputs();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        fc_exp       = 16'd0;
        size_err_exp = 1'b0;
    endtask

    // Control packet phase: accept the packet in IDLE, hold the encoder busy for
    // busy_n cycles, then release it; the send pulse is checked by drive_frame
    task automatic start_ctrl(input int w, input int h, input int busy_n);
        bus.vip_ctrl_valid = 1'b1;
        bus.width_in       = 16'(w);
        bus.height_in      = 16'(h);
        bus.vip_ctrl_busy  = 1'b1;
        #2;
        checks++;
        if (bus.frame_busy !== 1'b0) begin
            failures++;
            $display("FAIL ctrl_idle_busy got=%b exp=0", bus.frame_busy);
        end
        cyc();
        bus.vip_ctrl_valid = 1'b0;
        size_err_exp = (w != W) || (h != H);
        #2;
        checks++;
        if (bus.frame_busy !== 1'b1 || bus.vip_ctrl_send !== 1'b0) begin
            failures++;
            $display("FAIL ctrl_entry busy=%b send=%b exp busy=1 send=0", bus.frame_busy, bus.vip_ctrl_send);
        end
        checks++;
        if (bus.size_error !== size_err_exp) begin
            failures++;
            $display("FAIL size_error got=%b exp=%b (w=%0d h=%0d)", bus.size_error, size_err_exp, w, h);
        end
        checks++;
        if (bus.width_out !== 16'(W) || bus.height_out !== 16'(H)) begin
            failures++;
            $display("FAIL geometry got=%0dx%0d exp=%0dx%0d", bus.width_out, bus.height_out, W, H);
        end
        for (int i = 0; i < busy_n; i++) begin
            cyc();
            #2;
            checks++;
            if (bus.vip_ctrl_send !== 1'b0 || bus.src_ready !== 1'b0) begin
                failures++;
                $display("FAIL ctrl_busy_hold i=%0d send=%b ready=%b exp 0/0", i, bus.vip_ctrl_send, bus.src_ready);
            end
        end
        bus.vip_ctrl_busy = 1'b0;
        #2;
        checks++;
        if (bus.vip_ctrl_send !== 1'b0) begin
            failures++;
            $display("FAIL ctrl_send_early got=%b exp=0", bus.vip_ctrl_send);
        end
        cyc();
    endtask

    // Streams one frame. mode 0: no back-pressure; 1: sink stalls 3 cycles on
    // word 5; 2: core full for 2 cycles after 3 pixels; 3: random everything,
    // including stray control packets. abort_at >= 0 returns once that many
    // words have been accepted, leaving the frame mid-flight.
    task automatic drive_frame(input int mode, input int abort_at);
        int n_wr = 0, n_pop = 0, n_acc = 0, core_cnt = 0;
        int eov_seen = 0, stall_cnt = 0, full_cnt = 0, cycle = 0;
        bit exp_sw, exp_ready, exp_wr, exp_rd, exp_eov, acc, sv, fl, st, timed_out;
        timed_out = 1'b0;
        while (n_acc < TOTAL) begin
            if (abort_at >= 0 && n_acc == abort_at) break;
            if (cycle >= 300) begin
                checks++;
                failures++;
                $display("FAIL frame_timeout mode=%0d acc=%0d exp=%0d", mode, n_acc, TOTAL);
                timed_out = 1'b1;
                break;
            end
            exp_sw = (n_pop > n_acc);
            sv = 1'b1; fl = 1'b0; st = 1'b0;
            if (mode == 1) begin
                st = exp_sw && (n_acc == 4) && (stall_cnt < 3);
                if (st) stall_cnt++;
            end else if (mode == 2) begin
                fl = (n_wr == 3) && (full_cnt < 2);
                if (fl) full_cnt++;
            end else if (mode == 3) begin
                sv = ($urandom % 3) != 0;
                fl = ($urandom % 4) == 0;
                st = ($urandom % 3) == 0;
                bus.vip_ctrl_valid = ($urandom % 2) == 1;
                bus.width_in  = 16'(W);
                bus.height_in = 16'(H);
            end
            bus.src_valid  = sv;
            bus.core_full  = fl;
            bus.sink_stall = st;
            bus.core_empty = (core_cnt == 0);
            #2;
            exp_ready = !fl && (n_wr < TOTAL);
            exp_wr    = sv && exp_ready;
            exp_rd    = (core_cnt > 0) && (n_pop < TOTAL) && (!exp_sw || !st);
            exp_eov   = exp_sw && (n_acc == TOTAL - 1);
            checks++;
            if (bus.src_ready !== exp_ready) begin
                failures++;
                $display("FAIL src_ready mode=%0d cyc=%0d got=%b exp=%b", mode, cycle, bus.src_ready, exp_ready);
            end
            checks++;
            if (bus.core_wr_en !== exp_wr) begin
                failures++;
                $display("FAIL core_wr_en mode=%0d cyc=%0d got=%b exp=%b", mode, cycle, bus.core_wr_en, exp_wr);
            end
            checks++;
            if (bus.core_rd_en !== exp_rd) begin
                failures++;
                $display("FAIL core_rd_en mode=%0d cyc=%0d got=%b exp=%b", mode, cycle, bus.core_rd_en, exp_rd);
            end
            checks++;
            if (bus.sink_write !== exp_sw) begin
                failures++;
                $display("FAIL sink_write mode=%0d cyc=%0d got=%b exp=%b", mode, cycle, bus.sink_write, exp_sw);
            end
            checks++;
            if (bus.end_of_video_out !== exp_eov) begin
                failures++;
                $display("FAIL eov mode=%0d cyc=%0d got=%b exp=%b", mode, cycle, bus.end_of_video_out, exp_eov);
            end
            checks++;
            if (bus.vip_ctrl_send !== (cycle == 0) || bus.frame_busy !== 1'b1) begin
                failures++;
                $display("FAIL stream_status mode=%0d cyc=%0d send=%b busy=%b exp send=%b busy=1",
                         mode, cycle, bus.vip_ctrl_send, bus.frame_busy, (cycle == 0));
            end
            checks++;
            if (bus.size_error !== size_err_exp) begin
                failures++;
                $display("FAIL size_error_hold mode=%0d cyc=%0d got=%b exp=%b", mode, cycle, bus.size_error, size_err_exp);
            end
            if (bus.end_of_video_out === 1'b1) eov_seen++;
            acc = exp_sw && !st;
            cyc();
            n_wr     += int'(exp_wr);
            n_pop    += int'(exp_rd);
            n_acc    += int'(acc);
            core_cnt += int'(exp_wr) - int'(exp_rd);
            cycle++;
        end
        bus.vip_ctrl_valid = 1'b0;
        bus.src_valid      = 1'b0;
        bus.sink_stall     = 1'b0;
        bus.core_full      = 1'b0;
        if (timed_out) begin
            recover();
        end else if (abort_at < 0) begin
            checks++;
            if (n_wr !== TOTAL || n_pop !== TOTAL || eov_seen !== 1) begin
                failures++;
                $display("FAIL frame_totals mode=%0d wr=%0d pop=%0d eov=%0d exp %0d/%0d/1",
                         mode, n_wr, n_pop, eov_seen, TOTAL, TOTAL);
            end
            if (mode == 1) begin
                checks++;
                if (stall_cnt !== 3) begin
                    failures++;
                    $display("FAIL stall_cycles got=%0d exp=3", stall_cnt);
                end
            end
            if (mode == 2) begin
                checks++;
                if (full_cnt !== 2) begin
                    failures++;
                    $display("FAIL full_cycles got=%0d exp=2", full_cnt);
                end
            end
            #2;
            checks++;
            if (bus.frame_busy !== 1'b1 || bus.sink_write !== 1'b0 || bus.src_ready !== 1'b0) begin
                failures++;
                $display("FAIL done_cycle busy=%b sw=%b ready=%b exp 1/0/0", bus.frame_busy, bus.sink_write, bus.src_ready);
            end
            cyc();
            fc_exp = fc_exp + 16'd1;
            #2;
            checks++;
            if (bus.frame_busy !== 1'b0 || bus.frame_count !== fc_exp) begin
                failures++;
                $display("FAIL frame_end busy=%b count=%0d exp busy=0 count=%0d", bus.frame_busy, bus.frame_count, fc_exp);
            end
        end
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b0;
        cyc();
        cyc();
        #2;
        checks++;
        if (bus.frame_busy !== 1'b0 || bus.vip_ctrl_send !== 1'b0 || bus.sink_write !== 1'b0 ||
            bus.size_error !== 1'b0 || bus.frame_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_regs busy=%b send=%b sw=%b serr=%b fc=%0d exp all 0",
                     bus.frame_busy, bus.vip_ctrl_send, bus.sink_write, bus.size_error, bus.frame_count);
        end
        checks++;
        if (bus.width_out !== 16'(W) || bus.height_out !== 16'(H)) begin
            failures++;
            $display("FAIL reset_geometry got=%0dx%0d exp=%0dx%0d", bus.width_out, bus.height_out, W, H);
        end
        bus.src_valid = 1'b1;
        bus.core_empty = 1'b0;
        #1;
        checks++;
        if (bus.src_ready !== 1'b0 || bus.core_wr_en !== 1'b0 || bus.core_rd_en !== 1'b0 ||
            bus.end_of_video_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_comb ready=%b wr=%b rd=%b eov=%b exp all 0",
                     bus.src_ready, bus.core_wr_en, bus.core_rd_en, bus.end_of_video_out);
        end
        quiet_inputs();
        rst = 1'b1;
        cyc();
        fc_exp = 16'd0;
        size_err_exp = 1'b0;
    endtask

    task automatic test_abort();
        start_ctrl(W, H, 0);
        drive_frame(0, 5);
        quiet_inputs();
        rst = 1'b0;
        cyc();
        #2;
        checks++;
        if (bus.frame_busy !== 1'b0 || bus.frame_count !== fc_exp || bus.sink_write !== 1'b0 ||
            bus.end_of_video_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_state busy=%b fc=%0d sw=%b eov=%b exp 0/%0d/0/0",
                     bus.frame_busy, bus.frame_count, bus.sink_write, bus.end_of_video_out, fc_exp);
        end
        rst = 1'b1;
        cyc();
        start_ctrl(W, H, 0);
        drive_frame(0, -1);
    endtask

    task automatic test_stream();
        start_ctrl(W, H, 0);
        drive_frame(0, -1);
    endtask

    task automatic test_stall();
        start_ctrl(W, H, 2);
        drive_frame(1, -1);
    endtask

    task automatic test_core_full();
        start_ctrl(W, H, 1);
        drive_frame(2, -1);
    endtask

    task automatic test_size_error();
        start_ctrl(640, 480, 1);
        drive_frame(3, -1);
        start_ctrl(W, H, 0);
        drive_frame(0, -1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            start_ctrl(W, H, int'($urandom_range(0, 3)));
            drive_frame(3, -1);
        end
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_abort();
        test_stream();
        test_stall();
        test_core_full();
        test_size_error();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
